// File: rtl/led_pkg.sv
// Shared constants, types and helpers for the LED matrix scan controller.
// Pure declarations; no timing of its own.
// No flow control.
package led_pkg;

  localparam int NCOLS  = 16;
  localparam int NROWS  = 16;
  localparam int NSLOTS = 16;

  typedef logic [3:0]       col_t;
  typedef logic [NROWS-1:0] rowpat_t;
  typedef logic [3:0]       slot_t;
  typedef logic [3:0]       level_t;

  localparam col_t  LAST_COL  = col_t'(NCOLS - 1);
  localparam slot_t LAST_SLOT = slot_t'(NSLOTS - 1);

  // A PWM slot is lit when its index does not exceed the latched level, so
  // level 0 still lights one slot in sixteen and level 15 lights all of them.
  function automatic logic slot_lit(input slot_t slot, input level_t level);
    return (slot <= level);
  endfunction

endpackage

// File: rtl/led_pwm_timer.sv
// Cycle/slot timebase for the column scan: slot strobes, dwell and frame ends.
// Strobes are combinational from registered counters (same-cycle as the last cycle).
// Free-running; never stalls.
module led_pwm_timer
  import led_pkg::*;
#(
  parameter int SLOT_LEN = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] slot,
  output logic       slot_end,
  output logic       dwell_end,
  output logic       frame_end
);

  // A one-cycle slot still needs a 1-bit counter so the width is never zero.
  localparam int CW = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(SLOT_LEN - 1);

  logic [CW-1:0] cyc;

  // End-of-period strobes, all true in the final cycle of their period.
  always_comb begin
    slot_end  = (cyc == CYC_LAST);
    dwell_end = slot_end && (slot == LAST_SLOT);
    frame_end = dwell_end && (col == LAST_COL);
  end

  // Cycle counter wraps at SLOT_LEN-1; slot counter advances on each wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc  <= '0;
      slot <= '0;
    end else begin
      if (slot_end) begin
        cyc  <= '0;
        slot <= slot + 4'd1;
      end else begin
        cyc  <= cyc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_scan_ctrl.sv
// Double-buffered 16x16 LED frame store with column scan and per-dwell PWM.
// All outputs registered; row/col move on the same edge, swaps land at the 15->0 wrap.
// Writes stall (wr_ready=0) from the cycle after a swap request until the swap lands.
module led_scan_ctrl
  import led_pkg::*;
#(
  parameter int SLOT_LEN = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       bright,
  input  logic             wr_en,
  input  logic [3:0]       wr_col,
  input  logic [NROWS-1:0] wr_data,
  output logic             wr_ready,
  input  logic             swap_req,
  output logic             swap_done,
  output logic             frame_start,
  output logic [3:0]       col,
  output logic [NROWS-1:0] row
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  logic [0:0] state;
  logic [0:0] state_next;
  logic       front_sel;
  logic       front_next;
  logic       back_sel;
  logic       do_swap;
  logic       wr_fire;

  level_t     b_lat;
  level_t     b_lat_next;
  col_t       col_next;
  slot_t      slot;
  slot_t      slot_next;
  logic       slot_end;
  logic       dwell_end;
  logic       frame_end;
  rowpat_t    front_col;
  rowpat_t    row_next;

  rowpat_t    bank [2][NCOLS];

  led_pwm_timer #(
    .SLOT_LEN (SLOT_LEN)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .col       (col),
    .slot      (slot),
    .slot_end  (slot_end),
    .dwell_end (dwell_end),
    .frame_end (frame_end)
  );

  // Swap FSM: a request arms it, the next frame wrap fires it; requests while
  // armed are absorbed. A request on the wrap cycle itself only arms, since the
  // swap decision looks at the already-registered state.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (swap_req)  state_next = ST_PENDING;
      ST_PENDING: if (frame_end) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Bank selection and write qualification.
  always_comb begin
    do_swap    = (state == ST_PENDING) && frame_end;
    front_next = front_sel ^ do_swap;
    back_sel   = ~front_sel;
    wr_fire    = wr_en && wr_ready;
  end

  // Next scan position and dwell brightness. Brightness is only sampled at a
  // dwell boundary so the duty cycle is constant across a column's dwell.
  always_comb begin
    slot_next  = slot_end  ? (slot + 4'd1) : slot;
    col_next   = dwell_end ? (col + 4'd1)  : col;
    b_lat_next = dwell_end ? bright        : b_lat;
  end

  // Row pattern for the upcoming cycle, taken from the bank that will be the
  // front one after this edge so the swap cycle already shows the new frame.
  always_comb begin
    front_col = bank[front_next][col_next];
    row_next  = (en && slot_lit(slot_next, b_lat_next)) ? front_col : '0;
  end

  // Frame store: reset clears both banks; accepted writes target the back bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int c = 0; c < NCOLS; c++) begin
          bank[b][c] <= '0;
        end
      end
    end else if (wr_fire) begin
      bank[back_sel][wr_col] <= wr_data;
    end
  end

  // Swap state, bank pointer and write-ready handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      front_sel <= 1'b0;
      wr_ready  <= 1'b1;
    end else begin
      state     <= state_next;
      front_sel <= front_next;
      wr_ready  <= (state_next == ST_IDLE);
    end
  end

  // Scan position, latched brightness and the registered matrix drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      col   <= '0;
      b_lat <= '0;
      row   <= '0;
    end else begin
      col   <= col_next;
      b_lat <= b_lat_next;
      row   <= row_next;
    end
  end

  // Event pulses, aligned with the first col=0 cycle of the new frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_start <= 1'b0;
      swap_done   <= 1'b0;
    end else begin
      frame_start <= frame_end;
      swap_done   <= do_swap;
    end
  end

endmodule

// File: doc/led_scan_ctrl.md
# led_scan_ctrl

Scan controller for the 16×16 LED matrix: owns a double-buffered 16-column frame store, sequences the column scan (`col`, `row`) at a programmable dwell rate, and applies 16-level PWM brightness inside each column dwell. A host writes the back bank one column at a time and requests a bank swap. The swap is applied only at a frame boundary, so no torn frames are ever displayed. Sits between the host/pattern logic and the matrix row/column drivers.

## Interface
- `SLOT_LEN`, default 64: clk cycles per PWM slot. Each column dwell is 16·SLOT_LEN cycles; minimum value 1.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: display enable. When 0, `row` is forced to 0 and the scan keeps running.
- `bright` in 4: brightness level 0..15.
- `wr_en` in 1: back-bank column write strobe.
- `wr_col` in 4: column address for the write.
- `wr_data` in 16: row pattern for that column (bit i = row i lit).
- `wr_ready` out 1: write accepted when `wr_en && wr_ready`.
- `swap_req` in 1: request a front/back bank exchange.
- `swap_done` out 1: one-cycle pulse on the cycle the swap takes effect.
- `frame_start` out 1: one-cycle pulse when `col` wraps 15→0.
- `col` out 4: active column index.
- `row` out 16: row drive for the active column.

## Operation
- Storage: two banks, each 16 × 16 bits; `front_sel` selects the displayed bank. Writes always go to bank `!front_sel`.
- Reset values: `col`=0, `row`=0, both banks all-zero, `front_sel`=0, `swap_pending`=0, `wr_ready`=1, `swap_done`=0, `frame_start`=0, slot and cycle counters at 0, latched brightness = 0.
- Timing hierarchy:
  - Cycle counter runs 0..SLOT_LEN-1.
  - Slot counter runs 0..15 and advances when the cycle counter wraps.
  - Column advances when the slot counter wraps; `col` wraps 15→0. A frame is 16 dwells = 256·SLOT_LEN cycles.
- Brightness: `bright` is latched as `b_lat` on every column advance (and by reset), so it never changes mid-dwell. `row` = front[col] when `en && slot <= b_lat`, else 0.
  - `bright`=15 gives a 100% duty cycle.
  - `bright`=0 gives a 1/16 duty cycle. Full blanking is done only via `en`.
- Write: when `wr_en && wr_ready`, back[wr_col] ← wr_data at that edge. When `wr_en` is high and `wr_ready` is low, the write is dropped with no side effect.
- Swap:
  - `swap_req` while `swap_pending`=0 sets `swap_pending`=1 and drives `wr_ready`=0 from the next cycle.
  - At the first column-wrap edge (15→0) with `swap_pending`=1 already registered, on that edge: `front_sel` toggles, `swap_pending` clears, `wr_ready` returns to 1, and `swap_done` pulses.
  - `swap_req` while pending is ignored.
  - After a swap, the back bank holds the old front contents.
- Simultaneous events:
  - `wr_en` and `swap_req` in the same cycle: the write is accepted into the current back bank, then the swap is pending.
  - `swap_req` on the wrap cycle itself: it becomes pending and swaps at the next wrap, not the current one.
- `rst` mid-frame or mid-pending: everything returns to reset values on the next edge, any pending swap is discarded, and both banks are cleared.

## Timing
- `col`, `row`, `swap_done`, `frame_start` and `wr_ready` are all registered.
- `row` and `col` update on the same edge. `row` always corresponds to the `col` presented in the same cycle.
- `frame_start` and `swap_done` assert in the first cycle with `col`=0 of the new frame. That same cycle shows the new front bank's column 0.
- `en` and `bright` affect `row` with one cycle of latency (`bright` only at a dwell start).
- Write-to-display latency: visible only after the next completed swap.

## Structure
- Package `led_pkg`: constants NCOLS=16, NROWS=16, NSLOTS=16; types `col_t` (4-bit) and `rowpat_t` (16-bit).
- Sub-module `led_pwm_timer`: cycle and slot counters. Outputs `slot` (4-bit), `dwell_end` and `frame_end` strobes.
- Top level holds the banks, the swap FSM (IDLE ↔ PENDING) and the output registers.

## Test plan
Run all scenarios with SLOT_LEN=2 (dwell 32 cycles, frame 512 cycles).
- Reset: hold `rst` 3 cycles → `col`=0, `row`=0, `wr_ready`=1, no pulses. Scan `col` 0..15 with each value held 32 cycles; `frame_start` pulses every 512 cycles.
- Write then swap: write 16'hA5A5 to col 3, pulse `swap_req` → `wr_ready`=0 until the wrap. `swap_done` and `frame_start` pulse together; `row`=A5A5 during the col 3 dwell with `bright`=15.
- PWM: front col 0 = 16'hFFFF, `bright`=3 → `row`=FFFF for 8 cycles then 0 for 24 cycles of each col 0 dwell. Changing `bright` mid-dwell takes effect only at the next dwell.
- Dropped write: write 16'h1234 to col 5 while pending → after the swap, col 5 of the front bank is unchanged (0). A second `swap_req` while pending yields exactly one `swap_done`.
- Boundary: `swap_req` on the wrap cycle → no swap at that wrap; swap at the following wrap, 512 cycles later.
- `en`=0 for a full frame → `row`=0 throughout while `col` keeps scanning. Assert `rst` while pending → no `swap_done`, and all banks read 0 afterwards.
